// File: rtl/edge_arb_pkg.sv
// Shared types, constants and the round-robin winner search for edge_event_arbiter.
package edge_arb_pkg;

  typedef enum logic {IDLE, HOLD} state_t;

  localparam int unsigned DROP_CNT_W = 8;
  localparam int unsigned MAX_N      = 16;

  // First set bit of pend[0 +: n], searching from rr upward with wrap-around.
  // Returns 0 when nothing is pending; callers only use the result when pend != 0.
  function automatic logic [3:0] rr_pick(input logic [MAX_N-1:0] pend,
                                         input logic [3:0]       rr,
                                         input int unsigned      n);
    logic [3:0]  win;
    logic        found;
    int unsigned idx;
    win   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_N; i++) begin
      idx = (32'(rr) + i) % n;
      if (!found && (i < n) && pend[idx[3:0]]) begin
        win   = idx[3:0];
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/edge_detect.sv
// Per-channel rising-edge detector. The history flop resets high so a level
// already high when reset releases is not mistaken for an edge.
module edge_detect (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_level,
  output logic o_rise
);

  logic r_level_q;

  // Level history for edge detection.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_level_q <= 1'b1;
    else          r_level_q <= i_level;
  end

  assign o_rise = i_level & ~r_level_q;

endmodule

// File: rtl/edge_event_arbiter.sv
// Latches rising edges on N level channels as pending events and presents them
// one at a time on a valid/ready stream, round-robin between channels.
module edge_event_arbiter
  import edge_arb_pkg::*;
#(
  parameter int unsigned N    = 4,
  parameter int unsigned IDXW = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N-1:0]          level,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [IDXW-1:0]       out_idx,
  output logic [N-1:0]          pending,
  output logic                  drop,
  output logic [DROP_CNT_W-1:0] drop_count
);

  logic [N-1:0]          w_rise;
  logic [N-1:0]          w_load_mask;
  logic [N-1:0]          w_pending_next;
  logic [N-1:0]          w_drop_vec;
  logic [3:0]            w_win_full;
  logic [IDXW-1:0]       w_win;
  logic                  w_load;
  state_t                w_state_next;

  state_t                r_state;
  logic [N-1:0]          r_pending;
  logic [IDXW-1:0]       r_idx;
  logic [IDXW-1:0]       r_rr;
  logic                  r_drop;
  logic [DROP_CNT_W-1:0] r_drop_count;

  for (genvar g = 0; g < N; g++) begin : g_edge
    edge_detect u_edge_detect (
      .i_clk   (clk),
      .i_rst_n (reset),
      .i_level (level[g]),
      .o_rise  (w_rise[g])
    );
  end

  // Winner is always chosen from the registered (pre-update) pending set.
  assign w_win_full = rr_pick(16'(r_pending), 4'(r_rr), N);
  assign w_win      = w_win_full[IDXW-1:0];

  // Next state and load decision.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    case (r_state)
      IDLE: begin
        if (|r_pending) begin
          w_load       = 1'b1;
          w_state_next = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          if (|r_pending) w_load = 1'b1;
          else            w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Pending update: a new rise wins over the clear caused by loading.
  always_comb begin
    w_load_mask = '0;
    if (w_load) w_load_mask[w_win] = 1'b1;
    w_pending_next = (r_pending & ~w_load_mask) | w_rise;
    w_drop_vec     = w_rise & r_pending & ~w_load_mask;
  end

  // State, pending, output stage and round-robin pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_pending <= '0;
      r_idx     <= '0;
      r_rr      <= '0;
    end else begin
      r_state   <= w_state_next;
      r_pending <= w_pending_next;
      if (w_load) begin
        r_idx <= w_win;
        if (w_win == IDXW'(N - 1)) r_rr <= '0;
        else                       r_rr <= w_win + 1'b1;
      end
    end
  end

  // Drop pulse and saturating drop counter; simultaneous drops count once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_drop       <= 1'b0;
      r_drop_count <= '0;
    end else begin
      r_drop <= |w_drop_vec;
      if ((|w_drop_vec) && (r_drop_count != '1)) r_drop_count <= r_drop_count + 1'b1;
    end
  end

  assign out_valid  = (r_state == HOLD);
  assign out_idx    = r_idx;
  assign pending    = r_pending;
  assign drop       = r_drop;
  assign drop_count = r_drop_count;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed bench for edge_event_arbiter (N=4) with an out_idx scoreboard.
module tb_edge_event_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] level;
  logic       out_ready;
  logic       out_valid;
  logic [1:0] out_idx;
  logic [3:0] pending;
  logic       drop;
  logic [7:0] drop_count;

  int unsigned n_pass;
  int unsigned n_total;
  int unsigned sb[$];

  edge_event_arbiter #(.N(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .level      (level),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_idx    (out_idx),
    .pending    (pending),
    .drop       (drop),
    .drop_count (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // One clock; a handshake seen just before the edge pops the scoreboard.
  task automatic tick();
    logic        hs;
    logic [1:0]  idx;
    int unsigned exp_idx;
    hs  = out_valid && out_ready;
    idx = out_idx;
    @(posedge clk);
    #1;
    if (hs) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        exp_idx = sb.pop_front();
        chk("sb_idx", 32'(idx), exp_idx);
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    n_pass    = 0;
    n_total   = 0;
    reset     = 1'b0;
    level     = 4'b0000;
    out_ready = 1'b1;
    #1;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_idx", 32'(out_idx), 0);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_drop", 32'(drop), 0);
    chk("rst_drop_count", 32'(drop_count), 0);
    do_reset();

    // Single edge on channel 2.
    level = 4'b0100;
    sb.push_back(2);
    tick();
    chk("single_pending", 32'(pending), 4'b0100);
    chk("single_valid0", 32'(out_valid), 0);
    tick();
    chk("single_valid1", 32'(out_valid), 1);
    chk("single_idx", 32'(out_idx), 2);
    tick();
    chk("single_valid_drop", 32'(out_valid), 0);
    level = 4'b0000;
    tick();

    // Simultaneous edges from rr=0: grants 0,1,2,3 back to back.
    do_reset();
    level = 4'b1111;
    sb.push_back(0); sb.push_back(1); sb.push_back(2); sb.push_back(3);
    tick();
    chk("sim_pending_all", 32'(pending), 4'b1111);
    tick();
    chk("sim_idx0", 32'(out_idx), 0);
    chk("sim_pending_1110", 32'(pending), 4'b1110);
    tick();
    chk("sim_valid_b2b", 32'(out_valid), 1);
    tick();
    tick();
    tick();
    chk("sim_valid_end", 32'(out_valid), 0);
    chk("sim_pending_end", 32'(pending), 0);
    level = 4'b0000;
    tick();

    // Fairness: after granting 1 with 0011 pending, 0 wins next.
    out_ready = 1'b0;
    level = 4'b0010;
    tick();
    tick();
    chk("fair_first_idx", 32'(out_idx), 1);
    level = 4'b0001;
    tick();
    level = 4'b0011;
    tick();
    chk("fair_pending", 32'(pending), 4'b0011);
    chk("fair_no_drop", 32'(drop), 0);
    sb.push_back(1); sb.push_back(0); sb.push_back(1);
    out_ready = 1'b1;
    tick();
    chk("fair_wrap_idx", 32'(out_idx), 0);
    tick();
    tick();
    chk("fair_idle", 32'(out_valid), 0);
    level = 4'b0000;
    tick();

    // Backpressure with channel 3 presented; channel 0 rises twice.
    out_ready = 1'b0;
    level = 4'b1000;
    tick();
    tick();
    chk("bp_idx3", 32'(out_idx), 3);
    level = 4'b1001;
    tick();
    chk("bp_pending0", 32'(pending), 4'b0001);
    chk("bp_no_drop", 32'(drop), 0);
    level = 4'b1000;
    tick();
    level = 4'b1001;
    tick();
    chk("bp_drop", 32'(drop), 1);
    chk("bp_drop_count", 32'(drop_count), 1);
    chk("bp_pending_kept", 32'(pending), 4'b0001);
    tick();
    chk("bp_drop_pulse", 32'(drop), 0);
    chk("bp_idx_held", 32'(out_idx), 3);
    sb.push_back(3); sb.push_back(0);
    out_ready = 1'b1;
    tick();
    tick();
    chk("bp_drop_count_kept", 32'(drop_count), 1);
    level = 4'b0000;
    tick();

    // Same-cycle re-arm of channel 1 while it is loaded.
    out_ready = 1'b0;
    level = 4'b0100;
    tick();
    tick();
    level = 4'b0110;
    tick();
    level = 4'b0100;
    tick();
    sb.push_back(2); sb.push_back(1); sb.push_back(1);
    level = 4'b0110;
    out_ready = 1'b1;
    tick();
    chk("rearm_idx", 32'(out_idx), 1);
    chk("rearm_pending", 32'(pending), 4'b0010);
    chk("rearm_no_drop", 32'(drop), 0);
    chk("rearm_drop_count", 32'(drop_count), 1);
    tick();
    tick();
    chk("rearm_idle", 32'(out_valid), 0);
    level = 4'b0000;
    tick();
    chk("sb_drained", 32'(sb.size()), 0);

    // Asynchronous reset mid-HOLD with 0101 pending; level held high through release.
    out_ready = 1'b0;
    level = 4'b0001;
    tick();
    tick();
    level = 4'b0100;
    tick();
    level = 4'b0101;
    tick();
    chk("rst2_pre_pending", 32'(pending), 4'b0101);
    chk("rst2_pre_valid", 32'(out_valid), 1);
    #2;
    reset = 1'b0;
    #1;
    chk("rst2_valid", 32'(out_valid), 0);
    chk("rst2_pending", 32'(pending), 0);
    chk("rst2_drop_count", 32'(drop_count), 0);
    tick();
    reset = 1'b1;
    out_ready = 1'b1;
    tick();
    tick();
    tick();
    chk("rst2_no_event_pending", 32'(pending), 0);
    chk("rst2_no_event_valid", 32'(out_valid), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/edge_event_arbiter.md
# edge_event_arbiter

Multi-channel edge-event scheduler for the tick-generator datapath. It detects rising edges on N level inputs, latches each as a pending event, and hands events one at a time to a single shared consumer. Handoff uses a valid/ready handshake with round-robin fairness. It sits between the raw level sources and the downstream tick consumer, and replaces per-channel Moore/Mealy tick wiring with one arbitrated event stream.

## Interface
- N, default 4: number of level channels, 2..16.
- IDXW, default $clog2(N): width of the channel index. Derived; never overridden.
- clk  in  1  rising-edge clock for all state.
- reset  in  1  asynchronous, active-low. Value 0 resets all state immediately. Deassertion is synchronous to clk.
- level  in  N  per-channel levels, synchronous to clk.
- out_ready  in  1  consumer accepts the event presented this cycle.
- out_valid  out  1  an event is presented on out_idx.
- out_idx  out  IDXW  channel number of the presented event.
- pending  out  N  registered per-channel pending flags. Does not include the channel currently on out_idx.
- drop  out  1  one-cycle pulse: an edge arrived on a channel whose pending flag was already set.
- drop_count  out  8  saturating count of drops, stops at 255.

## Operation
- Edge detection per channel:
  - level_q[i] <= level[i] every cycle.
  - rise[i] = level[i] & ~level_q[i], combinational.
  - level_q resets to all-ones, so a level held high through reset release produces no event.
- Pending update each clock:
  - pending[i] is set when rise[i]=1.
  - pending[i] is cleared when channel i is loaded into the output stage.
  - Set has priority over clear: if channel i is loaded and rises in the same cycle, pending[i] stays 1.
- Drop: rise[i]=1 while pending[i]=1 and channel i is not being loaded that cycle.
  - pending[i] is unchanged.
  - drop pulses for one cycle.
  - drop_count increments by 1, saturating at 255.
  - Several channels dropping in the same cycle count once.
- FSM, two states, reset state IDLE:
  - IDLE: out_valid=0. If pending is nonzero, load the winner into out_idx and go to HOLD.
  - HOLD: out_valid=1 and out_idx is stable until the handshake.
  - HOLD, on out_valid & out_ready: if pending (the pre-update value) is nonzero, load the next winner and stay in HOLD. Otherwise go to IDLE.
  - HOLD without handshake: hold out_idx; no load happens.
- Round-robin arbitration:
  - Pointer rr, IDXW bits, resets to 0.
  - The winner is the first set pending bit searching rr, rr+1, … N-1, 0, … with wrap-around.
  - On each load, rr <= winner+1, wrapping to 0 at N (N need not be a power of two).
- Reset asserted mid-operation:
  - The presented event and all pending events are discarded.
  - out_valid=0, drop_count=0.
- Reset values of all outputs: out_valid=0, out_idx=0, pending=0, drop=0, drop_count=0.

## Timing
- Latency, idle arbiter:
  - level first sampled high at edge k: pending set after edge k.
  - out_valid=1 with that index after edge k+1.
- Throughput: one event per cycle while out_ready=1 and pending is nonzero, with no bubble between handshakes.
- out_valid and out_idx are registered. They never depend combinationally on out_ready or level.
- The consumer may hold out_ready low indefinitely. New edges keep accumulating in pending, one per channel; further edges on a pending channel are drops.
- drop is registered and asserted the cycle after the offending rise.

## Structure
- Package edge_arb_pkg holds:
  - state enum {IDLE, HOLD};
  - DROP_CNT_W = 8;
  - function rr_pick(pending, rr) returning the winner index.
- Sub-module edge_detect:
  - one instance per channel, generated;
  - contains level_q with its all-ones reset value;
  - outputs rise.
- Top level holds the pending register, FSM, rr pointer, output stage and drop counter.
- Expected size is roughly 150–250 lines.

## Test plan
- Single edge: N=4, out_ready=1. level[2] 0→1 at edge 10 → out_valid=1, out_idx=2 after edge 11; out_valid=0 after edge 12.
- Simultaneous: level 4'b1111 rises at once, rr=0, out_ready=1 → out_idx sequence 0,1,2,3 on consecutive cycles, then out_valid=0, pending=0.
- Fairness: after out_idx=1 is granted, pending becomes 4'b0011 → next grant is 0 (wrap), not 1.
- Backpressure and drop: out_ready=0 with channel 3 presented; channel 0 toggles 0→1→0→1 → first rise sets pending[0]; second rise gives drop=1 for one cycle and drop_count=1. After out_ready=1, out_idx goes 3 then 0.
- Same-cycle re-arm: channel 1 is loaded in the same cycle level[1] rises → pending[1]=1 afterwards and no drop.
- Reset: reset=0 mid-HOLD with pending=4'b0101 → out_valid, pending, drop_count all 0 asynchronously. level held high through reset release gives no event.
